// File: rtl/timer_pkg.sv
// Shared definitions for the multi-field timer: state encoding and the
// default field geometry (two base-60 fields of six bits each).
package timer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int DEF_NFIELD = 2;
    localparam int DEF_FW     = 6;
    localparam int DEF_MOD    = 60;

endpackage

// File: rtl/multi_field_timer_mod_counter.sv
// One time field: an FW-bit counter that cycles 0..MOD-1. The carry output
// is combinational so a whole chain of fields can ripple in a single cycle.
module mod_counter #(
    parameter int FW  = 6,
    parameter int MOD = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [FW-1:0] value,
    output logic          carry
);

    logic [FW-1:0] value_r;
    logic [FW-1:0] value_next_s;
    logic          at_max_s;

    assign at_max_s = (value_r == FW'(MOD - 1));
    assign carry    = inc & at_max_s;
    assign value    = value_r;

    // Next value: wrap to zero from MOD-1 so no value >= MOD is ever stored.
    always_comb begin
        value_next_s = value_r;
        if (inc) begin
            if (at_max_s) begin
                value_next_s = '0;
            end else begin
                value_next_s = value_r + FW'(1);
            end
        end else begin
            value_next_s = value_r;
        end
    end

    // Field register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
        end else begin
            value_r <= value_next_s;
        end
    end

endmodule

// File: rtl/multi_field_timer.sv
// Cascaded time-of-day style timer with run, pause and per-field adjust.
// Every decision is taken from the current state, so a tick arriving with a
// mode change is handled by the mode that was active when it was sampled.
module multi_field_timer
    import timer_pkg::*;
#(
    parameter int NFIELD = DEF_NFIELD,
    parameter int FW     = DEF_FW,
    parameter int MOD    = DEF_MOD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_run,
    input  logic                      tick_adj,
    input  logic                      adj,
    input  logic [$clog2(NFIELD)-1:0] adj_sel,
    input  logic                      pause,
    output logic [NFIELD*FW-1:0]      count,
    output logic                      running,
    output logic                      wrap
);

    state_t state_r;
    state_t state_next_s;
    logic   running_r;
    logic   wrap_r;
    logic   running_next_s;
    logic   wrap_next_s;

    for (genvar i = 0; i < NFIELD; i++) begin : g_field
        logic          inc_s;
        logic          carry_s;
        logic          carry_in_s;
        logic          sel_s;
        logic [FW-1:0] value_s;

        if (i == 0) begin : g_lsb
            assign carry_in_s = tick_run;
        end else begin : g_upper
            assign carry_in_s = g_field[i-1].carry_s;
        end

        // An out-of-range select matches no field, leaving all of them alone.
        assign sel_s = (int'(adj_sel) == i);

        // Field increment: ripple carry in RUN, isolated single field in ADJUST.
        always_comb begin
            inc_s = 1'b0;
            case (state_r)
                ST_RUN:    inc_s = carry_in_s;
                ST_ADJUST: inc_s = tick_adj & sel_s;
                default:   inc_s = 1'b0;
            endcase
        end

        mod_counter #(
            .FW  (FW),
            .MOD (MOD)
        ) u_field (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_s),
            .value (value_s),
            .carry (carry_s)
        );

        assign count[i*FW +: FW] = value_s;
    end

    // State register; reset returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: adj wins from any state; pause only toggles RUN/PAUSED.
    always_comb begin
        state_next_s = state_r;
        if (adj) begin
            state_next_s = ST_ADJUST;
        end else begin
            case (state_r)
                ST_RUN:    state_next_s = pause ? ST_PAUSED : ST_RUN;
                ST_PAUSED: state_next_s = pause ? ST_RUN : ST_PAUSED;
                ST_ADJUST: state_next_s = ST_PAUSED;
                default:   state_next_s = ST_RUN;
            endcase
        end
    end

    // Output decode: running follows the state being entered, wrap flags a
    // full rollover of the top field that only a RUN ripple can produce.
    always_comb begin
        running_next_s = (state_next_s == ST_RUN);
        if (state_r == ST_RUN) begin
            wrap_next_s = g_field[NFIELD-1].carry_s;
        end else begin
            wrap_next_s = 1'b0;
        end
    end

    // Registered status outputs, aligned with the count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_r <= 1'b1;
            wrap_r    <= 1'b0;
        end else begin
            running_r <= running_next_s;
            wrap_r    <= wrap_next_s;
        end
    end

    assign running = running_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_multi_field_timer.sv
// Bench for multi_field_timer with three base-60 fields. The reference model
// holds the time as one integer in base MOD; expected outputs are queued by
// the stimulus process and checked by an independent monitor.
module tb_multi_field_timer;

    localparam int NF   = 3;
    localparam int FW   = 6;
    localparam int MOD  = 60;
    localparam int SELW = $clog2(NF);
    localparam int SPAN = MOD * MOD * MOD;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick_run;
    logic            tick_adj;
    logic            adj;
    logic [SELW-1:0] adj_sel;
    logic            pause;
    logic [NF*FW-1:0] count;
    logic            running;
    logic            wrap;

    typedef struct {
        logic [NF*FW-1:0] count;
        logic             running;
        logic             wrap;
    } exp_t;

    exp_t q[$];
    int   total_n = 0;
    int   bad_n   = 0;
    int   m_total = 0;   // time value, field 0 is the least significant digit
    int   m_mode  = 0;   // 0 run, 1 paused, 2 adjust
    int   wrap_seen = 0;

    multi_field_timer #(
        .NFIELD (NF),
        .FW     (FW),
        .MOD    (MOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_run (tick_run),
        .tick_adj (tick_adj),
        .adj      (adj),
        .adj_sel  (adj_sel),
        .pause    (pause),
        .count    (count),
        .running  (running),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [NF*FW-1:0] pack(input int t);
        logic [NF*FW-1:0] v;
        int x;
        v = '0;
        x = t;
        for (int i = 0; i < NF; i++) begin
            v[i*FW +: FW] = FW'(x % MOD);
            x = x / MOD;
        end
        return v;
    endfunction

    function automatic int digit(input int t, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * MOD;
        return (t / p) % MOD;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show after it.
    task automatic cyc(input bit r, input bit tr, input bit ta, input bit a,
                       input int sel, input bit p);
        exp_t e;
        bit   w;
        int   d;
        int   pw;
        @(negedge clk);
        rst = r; tick_run = tr; tick_adj = ta; adj = a;
        adj_sel = SELW'(sel); pause = p;
        w = 1'b0;
        if (r) begin
            m_total = 0;
            m_mode  = 0;
        end else begin
            if (m_mode == 0 && tr) begin
                m_total = (m_total + 1) % SPAN;
                w = (m_total == 0);
            end else if (m_mode == 2 && ta && sel < NF) begin
                pw = 1;
                for (int i = 0; i < sel; i++) pw = pw * MOD;
                d = (m_total / pw) % MOD;
                m_total = m_total + (((d + 1) % MOD) - d) * pw;
            end
            if (a) m_mode = 2;
            else if (m_mode == 2) m_mode = 1;
            else if (p) m_mode = (m_mode == 0) ? 1 : 0;
        end
        e.count   = pack(m_total);
        e.running = (m_mode == 0);
        e.wrap    = w;
        if (w) wrap_seen++;
        q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Bring field f to value v in adjust mode (bounded by one full lap).
    task automatic set_field(input int f, input int v);
        for (int k = 0; k < MOD + 2 && digit(m_total, f) != v; k++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, f, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total_n++;
                if (count !== e.count) begin
                    bad_n++;
                    $display("FAIL count: got %h want %h at %0t", count, e.count, $time);
                end
                total_n++;
                if (running !== e.running) begin
                    bad_n++;
                    $display("FAIL running: got %b want %b at %0t", running, e.running, $time);
                end
                total_n++;
                if (wrap !== e.wrap) begin
                    bad_n++;
                    $display("FAIL wrap: got %b want %b at %0t", wrap, e.wrap, $time);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        bit a_lvl;
        rst = 1'b1; tick_run = 1'b0; tick_adj = 1'b0; adj = 1'b0;
        adj_sel = '0; pause = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);

        // 60 run ticks: field0 back to 0, field1 at 1, no wrap
        repeat (60) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle();

        // preload all fields to 59, release, resume, one tick -> full rollover
        for (int f = 0; f < NF; f++) set_field(f, MOD - 1);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle();
        idle();

        // adjust field1 through its wrap, tick_run ignored while adjusting
        set_field(1, MOD - 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1);

        // pause coincident with a tick still counts, later ticks do not
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // out-of-range select, then reset with a coincident tick in RUN
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle();

        // randomized traffic
        a_lvl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) a_lvl = ~a_lvl;
            cyc(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom), a_lvl,
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        total_n++;
        if (q.size() != 0) begin
            bad_n++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        total_n++;
        if (wrap_seen < 1) begin
            bad_n++;
            $display("FAIL rollover_scenario: got %0d wraps want >=1", wrap_seen);
        end
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
